pipe_wbu: RTL and testbench
===========================

# pipe_wbu

Write-back stage of the `liang` in-order pipeline. It is the receiving end of the EX→WB `exToWb_t` valid/ready handshake. It accepts one retiring micro-op at a time and waits a fixed number of cycles for synchronous-memory load data when required. It then writes the result into the register file and emits a one-cycle commit pulse with PC and a running retired-instruction count.

## Interface
Parameters:
- `LOAD_LAT`, default 1: cycles from the handshake cycle until `lsu_rdata_i` is valid; legal range 1..15.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `flush_i`  in  1  pipeline flush; the EX entry offered this cycle is discarded.
- `exToWb_i`  in  `exToWb_t`  retiring uop: `alu_res`, `lsu_res`, `uop_info`.
  - `uop_info` fields used: `pc`, `rd_idx`, `rd_wen`, `is_load`.
- `ex_valid_i`  in  1  EX holds a valid entry.
- `wb_ready_o`  out  1  WB accepts an entry this cycle.
- `lsu_rdata_i`  in  `ele_t`  load data, already extended by the LSU.
- `rf_wen_o`  out  1  register-file write enable.
- `rf_waddr_o`  out  5  destination register.
- `rf_wdata_o`  out  `ele_t`  write data.
- `commit_valid_o`  out  1  one instruction retires this cycle.
- `commit_pc_o`  out  `pc_t`  PC of the retiring instruction.
- `commit_cnt_o`  out  64  instructions retired since reset.

## Operation
- A handshake occurs when `ex_valid_i && wb_ready_o && !flush_i`.
  - The entry is captured on that clock edge, E0.
  - With `flush_i` high, `wb_ready_o` is unaffected and the offered entry is dropped.
- FSM states: EMPTY, WAIT_LD, COMMIT.
- EMPTY:
  - `wb_ready_o`=1.
  - On handshake: if `is_load`, go to WAIT_LD and set cnt=`LOAD_LAT`.
  - On handshake otherwise: go to COMMIT and set result=`alu_res`.
- WAIT_LD:
  - `wb_ready_o`=0.
  - Each edge: cnt←cnt−1.
  - At the edge where cnt==1: result←`lsu_rdata_i`, go to COMMIT.
- COMMIT:
  - `wb_ready_o`=1 and `commit_valid_o`=1.
  - `commit_pc_o`=held `pc`.
  - `rf_wen_o`=held `rd_wen && rd_idx!=0`.
  - `rf_waddr_o`=held `rd_idx`; `rf_wdata_o`=result.
  - At the edge: `commit_cnt_o`+1.
  - On a handshake in this same cycle, the next state is chosen as in EMPTY; otherwise go to EMPTY.
- Outputs in EMPTY and WAIT_LD:
  - `rf_wen_o`=0 and `commit_valid_o`=0.
  - `rf_waddr_o`, `rf_wdata_o` and `commit_pc_o` hold their last values.
- Loads wait for data even when `rd_wen`=0 or `rd_idx`=0. Stores and all other non-loads never wait.
- `flush_i` never kills a held entry. WB contents are always older than the flushing instruction.
- `commit_cnt_o` is 64 bits and wraps from 2^64−1 to 0.
- Reset values:
  - State EMPTY, cnt 0.
  - `wb_ready_o`=1; `rf_wen_o`=0; `commit_valid_o`=0.
  - `rf_waddr_o`=0, `rf_wdata_o`=0, `commit_pc_o`=0.
  - `commit_cnt_o`=0.
- Reset asserted mid-WAIT_LD or mid-COMMIT returns to EMPTY immediately. No commit is emitted and the counter is cleared.

## Timing
- Non-load, handshake in cycle N: commit pulse in cycle N+1.
- Load, handshake in cycle N:
  - `lsu_rdata_i` is sampled at the end of cycle N+`LOAD_LAT`.
  - Commit pulse in cycle N+`LOAD_LAT`+1.
- Throughput is one non-load per cycle: COMMIT with a handshake chains into COMMIT with no bubble.
- A load blocks new handshakes for `LOAD_LAT` cycles.
- `wb_ready_o` depends only on registered state. It has no combinational path from `ex_valid_i` or `flush_i`.
- `commit_valid_o`, `rf_wen_o`, `rf_waddr_o`, `rf_wdata_o` and `commit_pc_o` are driven from registers only. They have no combinational input-to-output path.

## Test plan
- **Single ALU op.** `pc`=0x80000000, `rd_idx`=5, `rd_wen`=1, `alu_res`=0x1234, valid in cycle 1.
  - Cycle 2: `commit_valid_o`=1, `rf_wen_o`=1, `rf_waddr_o`=5, `rf_wdata_o`=0x1234.
  - `commit_cnt_o`=1 afterwards.
- **Back-to-back ALU ops.** Three ALU ops valid in cycles 1–3 (`rd_idx` 1,2,3).
  - Commits in cycles 2,3,4; `wb_ready_o` stays 1.
  - `commit_cnt_o`=3.
- **Load latency.** Load with `LOAD_LAT`=1 accepted in cycle 1, `lsu_rdata_i`=0xdeadbeef in cycle 2 → commit in cycle 3 with `rf_wdata_o`=0xdeadbeef.
  - With `LOAD_LAT`=3: `wb_ready_o`=0 in cycles 2–4, commit in cycle 5.
- **x0 suppression.** Op with `rd_idx`=0, `rd_wen`=1 → `commit_valid_o`=1, `rf_wen_o`=0.
- **Flush.** `flush_i`=1 together with a valid ALU op in cycle 1 → no commit in cycle 2, `commit_cnt_o` unchanged.
  - `flush_i` pulsed during WAIT_LD → the load still commits on schedule.
- **Reset mid-load.** `rst_i` asserted during WAIT_LD → state EMPTY, all outputs at reset values.
  - No commit ever occurs for that load.

Source files
------------

// File: rtl/pipe_wbu.sv
// pipe_wbu: write-back stage of the liang pipeline, with load-latency wait and commit pulse.
package liang_pkg;
    typedef logic [31:0] ele_t;
    typedef logic [31:0] pc_t;
    typedef struct packed {
        pc_t        pc;
        logic [4:0] rd_idx;
        logic       rd_wen;
        logic       is_load;
    } uop_info_t;
    typedef struct packed {
        ele_t      alu_res;
        ele_t      lsu_res;
        uop_info_t uop_info;
    } exToWb_t;
endpackage

module pipe_wbu
    import liang_pkg::*;
#(
    parameter int LOAD_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  exToWb_t     exToWb_i,
    input  logic        ex_valid_i,
    output logic        wb_ready_o,
    input  ele_t        lsu_rdata_i,
    output logic        rf_wen_o,
    output logic [4:0]  rf_waddr_o,
    output ele_t        rf_wdata_o,
    output logic        commit_valid_o,
    output pc_t         commit_pc_o,
    output logic [63:0] commit_cnt_o
);
    typedef enum logic [1:0] {EMPTY, WAIT_LD, COMMIT} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q;
    pc_t        pc_q;
    logic [4:0] rd_q;
    logic       wen_q;
    logic       hs, ld_done, wen_src;
    logic [4:0] rd_src;
    logic       unused_lsu_res;

    assign unused_lsu_res = ^exToWb_i.lsu_res;
    assign wb_ready_o     = state_q != WAIT_LD;

    always_comb begin
        hs      = ex_valid_i && wb_ready_o && !flush_i;
        ld_done = state_q == WAIT_LD;
        rd_src  = ld_done ? rd_q : exToWb_i.uop_info.rd_idx;
        wen_src = ld_done ? wen_q : exToWb_i.uop_info.rd_wen;
        state_d = ld_done ? (cnt_q == 4'd1 ? COMMIT : WAIT_LD)
                          : (hs ? (exToWb_i.uop_info.is_load ? WAIT_LD : COMMIT) : EMPTY);
    end

    // Output registers load only when entering COMMIT so they hold their last values otherwise
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= EMPTY;
            cnt_q          <= '0;
            pc_q           <= '0;
            rd_q           <= '0;
            wen_q          <= 1'b0;
            commit_valid_o <= 1'b0;
            rf_wen_o       <= 1'b0;
            rf_waddr_o     <= '0;
            rf_wdata_o     <= '0;
            commit_pc_o    <= '0;
            commit_cnt_o   <= '0;
        end else begin
            state_q        <= state_d;
            commit_valid_o <= state_d == COMMIT;
            rf_wen_o       <= state_d == COMMIT && wen_src && rd_src != 5'd0;
            if (state_q == COMMIT)
                commit_cnt_o <= commit_cnt_o + 64'd1;
            if (hs) begin
                cnt_q <= 4'(LOAD_LAT);
                pc_q  <= exToWb_i.uop_info.pc;
                rd_q  <= exToWb_i.uop_info.rd_idx;
                wen_q <= exToWb_i.uop_info.rd_wen;
            end else if (ld_done) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (state_d == COMMIT) begin
                rf_waddr_o  <= rd_src;
                rf_wdata_o  <= ld_done ? lsu_rdata_i : exToWb_i.alu_res;
                commit_pc_o <= ld_done ? pc_q : exToWb_i.uop_info.pc;
            end
        end
    end
endmodule

// File: tb/tb_pipe_wbu.sv
// tb_pipe_wbu: directed table and sequence checks for pipe_wbu with LOAD_LAT 1 and 3.
module tb_pipe_wbu;
    import liang_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, v, v3;
    exToWb_t     ex;
    ele_t        lsu;
    logic        rdy, wen, cv;
    logic [4:0]  wa;
    ele_t        wd;
    pc_t         cpc;
    logic [63:0] cnt;
    logic        rdy3, wen3, cv3;
    logic [4:0]  wa3;
    ele_t        wd3;
    pc_t         cpc3;
    logic [63:0] cnt3;
    int          checks = 0;
    int          fails = 0;

    always #5 clk_i = ~clk_i;

    pipe_wbu dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .exToWb_i(ex), .ex_valid_i(v),
        .wb_ready_o(rdy), .lsu_rdata_i(lsu), .rf_wen_o(wen), .rf_waddr_o(wa), .rf_wdata_o(wd),
        .commit_valid_o(cv), .commit_pc_o(cpc), .commit_cnt_o(cnt)
    );

    pipe_wbu #(.LOAD_LAT(3)) dut3 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .exToWb_i(ex), .ex_valid_i(v3),
        .wb_ready_o(rdy3), .lsu_rdata_i(lsu), .rf_wen_o(wen3), .rf_waddr_o(wa3), .rf_wdata_o(wd3),
        .commit_valid_o(cv3), .commit_pc_o(cpc3), .commit_cnt_o(cnt3)
    );

    typedef struct {
        logic        v, fl;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] alu;
        logic        cv, ew;
        logic [4:0]  wa;
        logic [31:0] wd, epc;
        logic [63:0] cnt;
    } vec_t;

    vec_t tbl[9];

    function automatic vec_t mk(logic vv, logic fl, logic [31:0] pc, logic [4:0] rd, logic rw,
                                logic [31:0] alu, logic ecv, logic eew, logic [4:0] ewa,
                                logic [31:0] ewd, logic [31:0] epc, logic [63:0] ecnt);
        vec_t r;
        r.v = vv; r.fl = fl; r.pc = pc; r.rd = rd; r.rw = rw; r.alu = alu;
        r.cv = ecv; r.ew = eew; r.wa = ewa; r.wd = ewd; r.epc = epc; r.cnt = ecnt;
        return r;
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic vv, input logic ld, input logic [31:0] pc, input logic [4:0] rd,
                         input logic rw, input logic [31:0] alu);
        v = vv;
        ex.uop_info.is_load = ld;
        ex.uop_info.pc      = pc;
        ex.uop_info.rd_idx  = rd;
        ex.uop_info.rd_wen  = rw;
        ex.alu_res          = alu;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; v = 1'b0; v3 = 1'b0; lsu = '0; ex = '0;
        tbl[0] = mk(1, 0, 32'h80000000, 5,  1, 32'h1234,     1, 1, 5,  32'h1234,     32'h80000000, 0);
        tbl[1] = mk(1, 0, 32'h100,      1,  1, 32'h11,       1, 1, 1,  32'h11,       32'h100,      1);
        tbl[2] = mk(1, 0, 32'h104,      2,  1, 32'h22,       1, 1, 2,  32'h22,       32'h104,      2);
        tbl[3] = mk(1, 0, 32'h108,      3,  1, 32'h33,       1, 1, 3,  32'h33,       32'h108,      3);
        tbl[4] = mk(1, 0, 32'h10c,      0,  1, 32'h44,       1, 0, 0,  32'h44,       32'h10c,      4);
        tbl[5] = mk(1, 0, 32'h110,      7,  0, 32'h55,       1, 0, 7,  32'h55,       32'h110,      5);
        tbl[6] = mk(1, 1, 32'h200,      9,  1, 32'h99,       0, 0, 7,  32'h55,       32'h110,      6);
        tbl[7] = mk(0, 0, 32'h300,      10, 1, 32'h77,       0, 0, 7,  32'h55,       32'h110,      6);
        tbl[8] = mk(1, 0, 32'h114,      31, 1, 32'hffffffff, 1, 1, 31, 32'hffffffff, 32'h114,      6);
        step();
        step();
        chk("rst_ready", rdy, 1);
        chk("rst_cv", cv, 0);
        chk("rst_wen", wen, 0);
        chk("rst_wa", wa, 0);
        chk("rst_wd", wd, 0);
        chk("rst_pc", cpc, 0);
        chk("rst_cnt", cnt, 0);
        rst_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, 0, tbl[i].pc, tbl[i].rd, tbl[i].rw, tbl[i].alu);
            flush_i = tbl[i].fl;
            chk($sformatf("v%0d_ready", i), rdy, 1);
            step();
            chk($sformatf("v%0d_cv", i), cv, tbl[i].cv);
            chk($sformatf("v%0d_wen", i), wen, tbl[i].ew);
            chk($sformatf("v%0d_wa", i), wa, tbl[i].wa);
            chk($sformatf("v%0d_wd", i), wd, tbl[i].wd);
            chk($sformatf("v%0d_pc", i), cpc, tbl[i].epc);
            chk($sformatf("v%0d_cnt", i), cnt, tbl[i].cnt);
        end
        // load LAT=1 issued while committing, flush pulsed during the wait
        flush_i = 1'b0;
        drive(1, 1, 32'h400, 6, 1, 32'h0);
        step();
        chk("ld1_ready_wait", rdy, 0);
        chk("ld1_cv_wait", cv, 0);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        flush_i = 1'b1;
        lsu = 32'hdeadbeef;
        step();
        chk("ld1_cv", cv, 1);
        chk("ld1_wen", wen, 1);
        chk("ld1_wa", wa, 6);
        chk("ld1_wd", wd, 32'hdeadbeef);
        chk("ld1_pc", cpc, 32'h400);
        chk("ld1_cnt", cnt, 7);
        flush_i = 1'b0;
        lsu = '0;
        step();
        chk("ld1_after_cv", cv, 0);
        chk("ld1_after_wd_hold", wd, 32'hdeadbeef);
        chk("ld1_after_cnt", cnt, 8);
        // load to x0 with rd_wen=0 still waits for data
        drive(1, 1, 32'h500, 0, 0, 32'h0);
        step();
        chk("ldx0_ready_wait", rdy, 0);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        lsu = 32'hcafef00d;
        step();
        chk("ldx0_cv", cv, 1);
        chk("ldx0_wen", wen, 0);
        chk("ldx0_wd", wd, 32'hcafef00d);
        chk("ldx0_pc", cpc, 32'h500);
        step();
        chk("ldx0_cnt", cnt, 9);
        // LOAD_LAT=3 instance
        drive(0, 1, 32'h600, 4, 1, 32'h0);
        v3 = 1'b1;
        lsu = 32'hbad;
        step();
        v3 = 1'b0;
        chk("ld3_ready_c2", rdy3, 0);
        step();
        chk("ld3_ready_c3", rdy3, 0);
        step();
        chk("ld3_ready_c4", rdy3, 0);
        chk("ld3_cv_c4", cv3, 0);
        lsu = 32'h12345678;
        step();
        lsu = '0;
        chk("ld3_cv", cv3, 1);
        chk("ld3_wen", wen3, 1);
        chk("ld3_wa", wa3, 4);
        chk("ld3_wd", wd3, 32'h12345678);
        chk("ld3_pc", cpc3, 32'h600);
        chk("ld3_ready_c5", rdy3, 1);
        step();
        chk("ld3_cnt", cnt3, 1);
        chk("ld3_cv_after", cv3, 0);
        // asynchronous reset in the middle of a load wait
        drive(1, 1, 32'h700, 8, 1, 32'h0);
        step();
        chk("rl_ready_wait", rdy, 0);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        lsu = 32'h55;
        #2 rst_i = 1'b1;
        #1;
        chk("rl_ready", rdy, 1);
        chk("rl_cv", cv, 0);
        chk("rl_wen", wen, 0);
        chk("rl_wa", wa, 0);
        chk("rl_wd", wd, 0);
        chk("rl_pc", cpc, 0);
        chk("rl_cnt", cnt, 0);
        step();
        rst_i = 1'b0;
        step();
        chk("rl_cv_later", cv, 0);
        step();
        chk("rl_cv_later2", cv, 0);
        chk("rl_cnt_later", cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
